shared_mem_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single data-memory port among the processor's cores. Each core raises a request with address, write-enable and write data. The arbiter picks one eligible core, runs a fixed-latency memory access for it, and returns read data plus a one-cycle done pulse. Only cores with index below `io_NoC` are eligible, matching the core count the control unit uses.

---
 rtl/shared_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency data-memory port among NCORES cores.
// One transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
module shared_mem_arbiter #(
    parameter int unsigned NCORES  = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                       io_clock,
    input  logic                       io_rst,
    input  logic [15:0]                io_NoC,
    input  logic [NCORES-1:0]          io_req,
    input  logic [NCORES-1:0]          io_we,
    input  logic [NCORES*ADDR_W-1:0]   io_addr,
    input  logic [NCORES*DATA_W-1:0]   io_wdata,
    output logic [NCORES-1:0]          io_grant,
    output logic [NCORES-1:0]          io_done,
    output logic [DATA_W-1:0]          io_rdata,
    output logic                       io_busy,
    output logic                       io_mem_en,
    output logic                       io_mem_we,
    output logic [ADDR_W-1:0]          io_mem_addr,
    output logic [DATA_W-1:0]          io_mem_wdata,
    input  logic [DATA_W-1:0]          io_mem_rdata
);

    localparam int unsigned PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0]  gidx_q, gidx_d;
    logic [NCORES-1:0] grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NCORES-1:0] eligible;
    logic              found;
    logic [PTR_W-1:0]  sel;

    // First eligible core at or after rr_q, scanning with wrap-around.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            eligible[i] = io_req[i] && (i < 32'(io_NoC));
        end
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            int unsigned idx;
            idx = (32'(rr_q) + k) % NCORES;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = NCORES'(1) << sel;
                    gidx_d  = sel;
                    we_d    = io_we[sel];
                    addr_d  = io_addr[sel*ADDR_W +: ADDR_W];
                    wdata_d = io_wdata[sel*DATA_W +: DATA_W];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) rdata_d = io_mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                rr_d    = PTR_W'((32'(gidx_q) + 1) % NCORES);
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge io_clock or posedge io_rst) begin
        if (io_rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign io_grant     = grant_q;
    assign io_done      = (state_q == S_DONE) ? grant_q : '0;
    assign io_rdata     = rdata_q;
    assign io_busy      = (state_q != S_IDLE);
    assign io_mem_en    = (state_q == S_ISSUE);
    assign io_mem_we    = io_mem_en & we_q;
    assign io_mem_addr  = addr_q;
    assign io_mem_wdata = wdata_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed scenarios followed by random traffic, checked
// against a transaction-level round-robin model and a reference memory image.
module tb_shared_mem_arbiter;

    localparam int NC  = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       noc;
    logic [NC-1:0]     req, we;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  wdata;
    logic [NC-1:0]     io_grant, io_done;
    logic [DW-1:0]     io_rdata;
    logic              io_busy, io_mem_en, io_mem_we;
    logic [AW-1:0]     io_mem_addr;
    logic [DW-1:0]     io_mem_wdata, io_mem_rdata;

    shared_mem_arbiter #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .io_clock(clk), .io_rst(rst), .io_NoC(noc), .io_req(req), .io_we(we),
        .io_addr(addr), .io_wdata(wdata), .io_grant(io_grant), .io_done(io_done),
        .io_rdata(io_rdata), .io_busy(io_busy), .io_mem_en(io_mem_en),
        .io_mem_we(io_mem_we), .io_mem_addr(io_mem_addr), .io_mem_wdata(io_mem_wdata),
        .io_mem_rdata(io_mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_pat(input int a);
        return (a == 16) ? 16'hBEEF : (16'(a) * 16'h0101) ^ 16'h5A5A;
    endfunction

    // Memory with a LAT-cycle read pipeline; off-cycle data is poisoned.
    logic [15:0] mem  [0:255];
    logic [15:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_pat(k);
        end else if (io_mem_en && io_mem_we) begin
            mem[io_mem_addr[7:0]] <= io_mem_wdata;
        end
        pipe[0] <= (io_mem_en && !io_mem_we) ? mem[io_mem_addr[7:0]] : 16'hDEAD;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign io_mem_rdata = pipe[LAT-1];

    int          nchk = 0;
    int          nfail = 0;
    int          rr_m;
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_rdata;
    bit          keep [NC];
    int          g;
    logic [NC-1:0] obs;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        nchk++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("grant_onehot", 32'($onehot0(io_grant)), 1);
        chk("done_in_grant", 32'(io_done & ~io_grant), 0);
    endtask

    task automatic set_core(input int i, input logic r, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
        req[i] = r;
        we[i]  = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic reset_model();
        rr_m = 0;
        exp_rdata = '0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_pat(k);
    endtask

    function automatic int predict();
        for (int k = 0; k < NC; k++) begin
            int i;
            i = (rr_m + k) % NC;
            if (req[i] && i < int'(noc)) return i;
        end
        return -1;
    endfunction

    // Entered and left at a negedge in an IDLE cycle; runs one complete transaction.
    task automatic do_txn(output int gx, output logic [NC-1:0] gobs);
        logic        ewe;
        logic [15:0] ea, ed, saved_noc;
        gx = predict();
        gobs = '0;
        chk("idle_busy", 32'(io_busy), 0);
        chk("idle_grant", 32'(io_grant), 0);
        if (gx < 0) begin
            tick();
            chk("nogrant_busy", 32'(io_busy), 0);
            chk("nogrant_grant", 32'(io_grant), 0);
            return;
        end
        ewe = we[gx];
        ea  = addr[gx*AW +: AW];
        ed  = wdata[gx*DW +: DW];
        tick();
        gobs = io_grant;
        chk("issue_grant", 32'(io_grant), 32'(1) << gx);
        chk("issue_busy", 32'(io_busy), 1);
        chk("issue_mem_en", 32'(io_mem_en), 1);
        chk("issue_mem_we", 32'(io_mem_we), 32'(ewe));
        chk("issue_mem_addr", 32'(io_mem_addr), 32'(ea));
        if (ewe) chk("issue_mem_wdata", 32'(io_mem_wdata), 32'(ed));
        chk("issue_done", 32'(io_done), 0);
        if (ewe) ref_mem[ea[7:0]] = ed;
        else     exp_rdata = ref_mem[ea[7:0]];
        // Inputs outside IDLE must be ignored.
        saved_noc = noc;
        for (int c = 0; c < LAT; c++) begin
            noc = 16'($urandom_range(0, 5));
            tick();
            chk("wait_mem_en", 32'(io_mem_en), 0);
            chk("wait_grant", 32'(io_grant), 32'(1) << gx);
            chk("wait_busy", 32'(io_busy), 1);
            chk("wait_done", 32'(io_done), 0);
        end
        noc = saved_noc;
        tick();
        chk("done_pulse", 32'(io_done), 32'(1) << gx);
        chk("done_grant", 32'(io_grant), 32'(1) << gx);
        chk("done_rdata", 32'(io_rdata), 32'(exp_rdata));
        chk("done_mem_en", 32'(io_mem_en), 0);
        rr_m = (gx + 1) % NC;
        if (!keep[gx]) req[gx] = 1'b0;
        tick();
        chk("after_done", 32'(io_done), 0);
    endtask

    initial begin
        rst = 1'b1; noc = 16'd4; req = '0; we = '0; addr = '0; wdata = '0;
        for (int k = 0; k < NC; k++) keep[k] = 0;
        reset_model();
        tick(); tick();
        chk("rst_grant", 32'(io_grant), 0);
        chk("rst_done", 32'(io_done), 0);
        chk("rst_rdata", 32'(io_rdata), 0);
        chk("rst_busy", 32'(io_busy), 0);
        chk("rst_mem_en", 32'(io_mem_en), 0);
        chk("rst_mem_we", 32'(io_mem_we), 0);
        chk("rst_mem_addr", 32'(io_mem_addr), 0);
        chk("rst_mem_wdata", 32'(io_mem_wdata), 0);
        rst = 1'b0;
        tick();

        // Single read by core 1.
        set_core(1, 1, 0, 16'h0010, 16'h0);
        do_txn(g, obs);
        chk("t1_grant", 32'(obs), 32'h2);
        chk("t1_rdata", 32'(io_rdata), 32'hBEEF);

        // Restart from rr=0, all four holding until done.
        rst = 1'b1; tick(); rst = 1'b0; reset_model(); tick();
        for (int i = 0; i < NC; i++) set_core(i, 1, 0, 16'(i + 3), 16'h0);
        for (int k = 0; k < NC; k++) begin
            do_txn(g, obs);
            chk("t2_order", 32'(obs), 32'(1) << k);
        end

        // Cores 0 and 2 requesting continuously alternate.
        keep[0] = 1; keep[2] = 1;
        set_core(0, 1, 0, 16'h0005, 16'h0);
        set_core(2, 1, 0, 16'h0007, 16'h0);
        for (int k = 0; k < 4; k++) begin
            do_txn(g, obs);
            chk("t3_alternate", 32'(obs), (k % 2 == 0) ? 32'h1 : 32'h4);
        end

        // NoC limits eligibility.
        noc = 16'd2;
        for (int i = 0; i < NC; i++) begin keep[i] = 1; set_core(i, 1, 0, 16'(i), 16'h0); end
        for (int k = 0; k < 4; k++) begin
            do_txn(g, obs);
            chk("t4_noc2", 32'(obs & 4'b1100), 0);
        end
        noc = 16'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_noc0_busy", 32'(io_busy), 0);
            chk("t4_noc0_grant", 32'(io_grant), 0);
        end
        for (int i = 0; i < NC; i++) begin keep[i] = 0; req[i] = 1'b0; end
        noc = 16'd4;
        tick();

        // Write leaves rdata alone, later read returns the written value.
        set_core(3, 1, 1, 16'h0040, 16'h1234);
        do_txn(g, obs);
        chk("t5_wr_grant", 32'(obs), 32'h8);
        chk("t5_wr_rdata", 32'(io_rdata), 32'(exp_rdata));
        set_core(0, 1, 0, 16'h0040, 16'h0);
        do_txn(g, obs);
        chk("t5_rd_rdata", 32'(io_rdata), 32'h1234);

        // Reset during WAIT aborts without done; arbitration restarts at 0.
        set_core(2, 1, 0, 16'h0002, 16'h0);
        do_txn(g, obs);
        set_core(0, 1, 0, 16'h0001, 16'h0);
        tick();
        chk("t6_pre_grant", 32'(io_grant), 32'h1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_async_grant", 32'(io_grant), 0);
        chk("t6_async_busy", 32'(io_busy), 0);
        chk("t6_async_mem_en", 32'(io_mem_en), 0);
        chk("t6_async_done", 32'(io_done), 0);
        req[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_rst_done", 32'(io_done), 0);
        end
        rst = 1'b0; reset_model();
        tick();
        chk("t6_post_done", 32'(io_done), 0);
        set_core(2, 1, 0, 16'h0003, 16'h0);
        set_core(3, 1, 0, 16'h0004, 16'h0);
        do_txn(g, obs);
        chk("t6_restart", 32'(obs), 32'h4);
        req = '0;
        tick();

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NC; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1)
                    set_core(i, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                             16'($urandom));
            end
            if ($urandom_range(0, 3) == 0) noc = 16'($urandom_range(0, 5));
            do_txn(g, obs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
